// File: rtl/pipe_stage_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_fifo
// Purpose  : Elastic stage register for the RV32I pipeline. Buffers up to
//            DEPTH entries of an arbitrary packed payload behind a
//            valid/ready handshake. Offers a synchronous flush for squashing
//            and presents an all-zero payload (a bubble) when empty.
// Ports    : clk           - clock, rising edge
//            rst_n         - asynchronous active-low reset
//            flush         - synchronous squash of all entries and same-cycle input
//            in_valid      - upstream payload valid
//            in_ready      - buffer can accept this cycle
//            in_data       - upstream payload [DATA_W]
//            out_valid     - head entry valid
//            out_ready     - downstream accepts head this cycle
//            out_data      - head payload, zero when out_valid=0 [DATA_W]
//            count         - current occupancy 0..DEPTH [CNT_W]
//            stall_cycles  - (PIPE_STAGE_FIFO_PERF_EN) cycles with valid & ~ready
//            bubble_cycles - (PIPE_STAGE_FIFO_PERF_EN) cycles with ~valid & ready
// Options  : define PIPE_STAGE_FIFO_PERF_EN to add the saturating stall/bubble
//            performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count
`ifdef PIPE_STAGE_FIFO_PERF_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       bubble_cycles
`endif
);

    localparam int               c_PTR_W     = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic w_push;
    logic w_pop;

    // Handshake status depends on registered occupancy only, so there is no
    // combinational path from out_ready to in_ready.
    assign in_ready  = (r_count != c_DEPTH_CNT);
    assign out_valid = (r_count != '0);
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
    assign count     = r_count;

    // flush dominates: it cancels any same-cycle transfer on either side.
    assign w_push = in_valid & in_ready & ~flush;
    assign w_pop  = out_valid & out_ready & ~flush;

    // Pointers and occupancy. Pointers are log2(DEPTH) wide so they wrap
    // from DEPTH-1 to 0 by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is intentionally left unreset; stale entries are hidden by
    // out_valid and the zeroed out_data.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

`ifdef PIPE_STAGE_FIFO_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_bubble_cycles;

    // Saturating counters; only rst_n clears them so flush cannot hide stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles  <= '0;
            r_bubble_cycles <= '0;
        end else begin
            if (out_valid && !out_ready && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (!out_valid && out_ready && (r_bubble_cycles != '1)) begin
                r_bubble_cycles <= r_bubble_cycles + 32'd1;
            end
        end
    end

    assign stall_cycles  = r_stall_cycles;
    assign bubble_cycles = r_bubble_cycles;
`endif

    a_count_range : assert property (@(posedge clk) disable iff (!rst_n)
        r_count <= c_DEPTH_CNT);

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_fifo
// Purpose  : Scoreboard bench for pipe_stage_fifo. One DEPTH=2 and one
//            DEPTH=4 instance share the input stimulus; sel picks which
//            instance the handshake and monitor observe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_fifo;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        flush     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data   = '0;
    logic        sel       = 1'b0;

    logic        in_ready2, out_valid2, in_ready4, out_valid4;
    logic [31:0] out_data2, out_data4;
    logic [1:0]  count2;
    logic [2:0]  count4;
`ifdef PIPE_STAGE_FIFO_PERF_EN
    logic [31:0] stall2, bubble2, stall4, bubble4;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    pipe_stage_fifo #(.DATA_W(32), .DEPTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .count(count2)
`ifdef PIPE_STAGE_FIFO_PERF_EN
        , .stall_cycles(stall2), .bubble_cycles(bubble2)
`endif
    );

    pipe_stage_fifo #(.DATA_W(32), .DEPTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .count(count4)
`ifdef PIPE_STAGE_FIFO_PERF_EN
        , .stall_cycles(stall4), .bubble_cycles(bubble4)
`endif
    );

    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_data, s_count, s_depth;
    assign s_in_ready  = sel ? in_ready4  : in_ready2;
    assign s_out_valid = sel ? out_valid4 : out_valid2;
    assign s_out_data  = sel ? out_data4  : out_data2;
    assign s_count     = sel ? 32'(count4) : 32'(count2);
    assign s_depth     = sel ? 32'd4 : 32'd2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted head is compared with the scoreboard front.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("count_range", 32'(s_count <= s_depth), 32'd1);
            if (!s_out_valid) begin
                chk("bubble_zero", s_out_data, 32'd0);
            end
            if (s_out_valid && out_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", s_out_data, 32'hDEAD_BEEF);
                end else begin
                    chk("out_data", s_out_data, exp_q.pop_front());
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the push is accepted.
    task automatic push(input logic [31:0] d, input bit rnd);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 50; i++) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (s_in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) chk("push_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (s_count == 0 && exp_q.size() == 0) break;
        end
        chk("drain_count", s_count, 32'd0);
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input logic which);
        #1 rst_n = 1'b0;
        sel = which;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- DEPTH=2: reset state -----------------------------
        do_reset(1'b0);
        @(negedge clk);
        chk("rst_count", s_count, 32'd0);
        chk("rst_in_ready", 32'(s_in_ready), 32'd1);
        chk("rst_out_valid", 32'(s_out_valid), 32'd0);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a cycle holding one entry
        out_ready = 1'b0;
        push(32'h77, 1'b0);
        @(negedge clk);
        chk("pre_rst_count", s_count, 32'd1);
        chk("pre_rst_data", s_out_data, 32'h77);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_count", s_count, 32'd0);
        chk("async_rst_out_valid", 32'(s_out_valid), 32'd0);
        chk("async_rst_out_data", s_out_data, 32'd0);
        chk("async_rst_in_ready", 32'(s_in_ready), 32'd1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ---------------- Streaming --------------------------------------
        out_ready = 1'b1;
        exp_q.push_back(32'h11);
        exp_q.push_back(32'h22);
        exp_q.push_back(32'h33);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h11 * (i + 1);
            @(negedge clk);
            if (i > 0) chk("stream_count", s_count, 32'd1);
            chk("stream_in_ready", 32'(s_in_ready), 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_tail_count", s_count, 32'd1);
        chk("stream_tail_data", s_out_data, 32'h33);
        @(posedge clk); #1;
        drain();

        // ---------------- Backpressure -----------------------------------
        out_ready = 1'b0;
        exp_q.push_back(32'hA);
        exp_q.push_back(32'hB);
        exp_q.push_back(32'hC);
        push(32'hA, 1'b0);
        push(32'hB, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'hC;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("full_count", s_count, 32'd2);
            chk("full_in_ready", 32'(s_in_ready), 32'd0);
            chk("full_head", s_out_data, 32'hA);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        push(32'hC, 1'b0);
        drain();

        // ---------------- DEPTH=4: wrap with random out_ready ------------
        do_reset(1'b1);
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(32'h100 + 32'(i));
            push(32'h100 + 32'(i), 1'b1);
        end
        drain();

        // ---------------- Flush with push and pop at count=3 -------------
        out_ready = 1'b0;
        push(32'hF1, 1'b0);
        push(32'hF2, 1'b0);
        push(32'hF3, 1'b0);
        @(negedge clk);
        chk("preflush_count", s_count, 32'd3);
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_data   = 32'hF4;
        out_ready = 1'b1;
        flush     = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        chk("flush_count", s_count, 32'd0);
        chk("flush_out_valid", 32'(s_out_valid), 32'd0);
        chk("flush_in_ready", 32'(s_in_ready), 32'd1);
        @(posedge clk); #1;
        exp_q.push_back(32'h55);
        push(32'h55, 1'b0);
        drain();

`ifdef PIPE_STAGE_FIFO_PERF_EN
        // ---------------- Performance counters ---------------------------
        out_ready = 1'b0;
        do_reset(1'b1);
        exp_q.push_back(32'h66);
        push(32'h66, 1'b0);
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("stall_cycles", stall4, 32'd5);
        chk("bubble_cycles", bubble4, 32'd3);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("stall_after_flush", stall4, 32'd5);
        chk("bubble_after_flush", bubble4, 32'd3);
        chk("perf_queue", 32'(exp_q.size()), 32'd0);
`endif

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
